// File: rtl/messenger_rx.sv
// messenger_rx: 8N1 UART receiver that loads STX/ETX-framed text into the
// Document RAM through a write port with a grant handshake.
//   clk, rst (async, active-low)   system clock / reset
//   RsRx                           serial line from the PC, idle high
//   write_ready                    Document port grant for the pending write
//   write_en/write_addr/write_data pending write, held until granted
//   busy                           between an accepted STX and its ETX
//   load_done                      one-cycle pulse when ETX closes a load
//   frame_err, overrun, overflow   sticky error flags
module messenger_rx #(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned BAUD      = 9600,
  parameter int unsigned DOC_DEPTH = 512,
  parameter int unsigned ADDR_W    = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RsRx,
  input  logic              write_ready,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic [7:0]        write_data,
  output logic              busy,
  output logic              load_done,
  output logic              frame_err,
  output logic              overrun,
  output logic              overflow
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned PTR_W        = $clog2(DOC_DEPTH + 1);
  localparam logic [7:0]  STX          = 8'h02;
  localparam logic [7:0]  ETX          = 8'h03;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [2:0]         bit_idx, bit_idx_d;
  logic [7:0]         shift, shift_d;
  logic               stop_bad, stop_bad_d;
  logic               byte_valid, byte_valid_d;
  logic               frame_err_set;
  logic               rx_meta, rx_s;
  logic [PTR_W-1:0]   ptr;

  // Two-flop synchroniser for the asynchronous serial line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RsRx;
      rx_s    <= rx_meta;
    end
  end

  // Receiver state and bit-timing registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      stop_bad   <= 1'b0;
      byte_valid <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      bit_idx    <= bit_idx_d;
      shift      <= shift_d;
      stop_bad   <= stop_bad_d;
      byte_valid <= byte_valid_d;
    end
  end

  // Receiver next-state: start validated at half bit, then full-bit sampling
  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    bit_idx_d     = bit_idx;
    shift_d       = shift;
    stop_bad_d    = stop_bad;
    byte_valid_d  = 1'b0;
    frame_err_set = 1'b0;
    case (state)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt == CNT_W'(HALF_BIT - 1)) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift[7:1]};
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (stop_bad) begin
          // Bad stop bit: wait for the line to return high before rearming
          if (rx_s) begin
            stop_bad_d = 1'b0;
            state_d    = IDLE;
          end
        end else if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_valid_d = 1'b1;
            state_d      = IDLE;
          end else begin
            frame_err_set = 1'b1;
            stop_bad_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Load framing and write handshake; an accept in the same cycle as a new
  // byte is processed first, so the later write_en assignment wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      overflow   <= 1'b0;
      ptr        <= '0;
    end else begin
      load_done <= 1'b0;
      if (frame_err_set) frame_err <= 1'b1;
      if (write_en && write_ready) write_en <= 1'b0;
      if (byte_valid) begin
        if (shift == STX) begin
          busy     <= 1'b1;
          ptr      <= '0;
          overflow <= 1'b0;
        end else if (shift == ETX) begin
          if (busy) begin
            busy      <= 1'b0;
            load_done <= 1'b1;
          end
        end else if (busy) begin
          if (ptr == PTR_W'(DOC_DEPTH)) begin
            overflow <= 1'b1;
          end else if (write_en && !write_ready) begin
            overrun <= 1'b1;
          end else begin
            write_en   <= 1'b1;
            write_addr <= ADDR_W'(ptr);
            write_data <= shift;
            ptr        <= ptr + PTR_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: doc/messenger_rx.md
Name: messenger_rx

Overview:
- UART receiver (8N1), the receive-side counterpart of the messenger transmitter.
- Deserialises bytes from the PC on RsRx and loads them into the Document RAM through a write port with a grant handshake.
- A load is framed by control bytes: STX (0x02) opens a load and ETX (0x03) closes it. Payload bytes are written to consecutive document addresses starting at 0.
- Sits beside messenger; text_editor arbitrates its Document port between this block and the recogniser path.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated (10416 at defaults).
- DOC_DEPTH, 512, number of document cells; addresses 0..DOC_DEPTH-1.
- ADDR_W, 9, write address width; must satisfy 2^ADDR_W >= DOC_DEPTH.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- RsRx  input  1  UART serial line; idle high; asynchronous to clk.
- write_ready  input  1  Document port grant for the pending write.
- write_en  output  1  write request; held until accepted.
- write_addr  output  ADDR_W  document address of the pending write.
- write_data  output  8  character to write.
- busy  output  1  high between an accepted STX and the matching ETX.
- load_done  output  1  one-cycle pulse when ETX closes a load.
- frame_err  output  1  sticky; a stop bit was sampled low.
- overrun  output  1  sticky; a byte completed while a write was still pending.
- overflow  output  1  sticky; payload exceeded DOC_DEPTH.

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, FSM in IDLE, bit counter, baud counter and write pointer 0, synchroniser flops set to 1.
- Input conditioning: RsRx passes through a 2-flop synchroniser; all sampling uses the synchronised value rx_s.
- Receiver FSM states: IDLE, START, DATA, STOP.
  - IDLE: baud counter held at 0. A falling rx_s moves to START.
  - START: count to CLKS_PER_BIT/2 - 1, then re-sample. If rx_s is 0, clear the baud counter and go to DATA. If rx_s is 1, the start was a glitch: return to IDLE, no error flagged.
  - DATA: every CLKS_PER_BIT clocks, sample rx_s at bit centre and shift LSB-first into an 8-bit shift register. After bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT clocks, sample. If 1, assert byte_valid internally for one cycle. If 0, set frame_err, discard the byte, and stay in STOP until rx_s is 1 before returning to IDLE.
- Load framing, evaluated on byte_valid:
  - STX: set busy=1, write pointer=0, clear overflow. A pending write is not cancelled. STX while already busy restarts the load at pointer 0.
  - ETX while busy: busy=0, load_done pulses one cycle later, on the cycle after byte_valid. ETX while idle is ignored.
  - Any other byte while busy, pointer < DOC_DEPTH: latch byte and pointer into write_data/write_addr, assert write_en, increment pointer.
  - Any other byte while busy, pointer = DOC_DEPTH: drop the byte, set overflow.
  - Any byte while not busy (other than STX): ignored.
- Write handshake:
  - write_en, write_addr and write_data hold stable until a cycle where write_en and write_ready are both 1.
  - write_en drops on the following cycle, giving exactly one write per byte.
  - write_ready while write_en is 0 has no effect.
- Boundary cases:
  - A new payload byte arriving while write_en is still high is dropped, sets overrun, and does not advance the pointer.
  - byte_valid and the write acceptance in the same cycle: the accept completes first, then the new byte is latched. write_en stays high with the new data, so no overrun is flagged.
- Latency:
  - write_en rises 1 cycle after byte_valid.
  - byte_valid occurs about 9.5 bit-times after the start-bit falling edge.
- Sticky flags: cleared only by reset (overflow is also cleared by STX).

Test Plan:
- Send 0x02, 'H'(0x48), 'I'(0x49), 0x03 with write_ready tied 1 -> writes (0,0x48) and (1,0x49); busy high from STX to ETX; one load_done pulse; no flags set.
- Send 0x02, 'A'(0x41) with write_ready held 0 for 2000 cycles, then 1 -> write_en steady with addr 0, data 0x41 throughout; exactly one accepted write.
- Send 0x02, 0x41, then 0x42 while write_ready is held 0 for 2 bit-times -> overrun=1; only (0,0x41) is written once granted; pointer=1.
- Send 0x02 followed by 513 payload bytes -> addresses 0..511 each written once; the 513th byte is dropped; overflow=1; a following 0x02 clears overflow.
- Send a frame with its stop bit driven low, then a valid 0x02 -> frame_err=1; the bad byte is discarded; busy=1 after the STX.
- Send a 0.3-bit-time low glitch on RsRx, then pull rst low in the middle of a DATA byte -> glitch produces no byte; on reset, all outputs go 0 immediately and the next frame decodes correctly.
